serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter N, default 4: number of data bits per frame, N >= 2.
REQ-002 Parameter PARITY_EN, default 1: 1 means one even-parity bit follows the data; 0 means no parity bit.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 sd  input  1  serial data line; a parallel-load right-shift register's serial output drives it, so data arrives LSB first.
REQ-006 sd_en  input  1  bit strobe; sd is sampled only on cycles with sd_en=1.
REQ-007 out_data  output  N  received data word.
REQ-008 out_perr  output  1  parity-error flag accompanying out_data; 0 when PARITY_EN=0.
REQ-009 out_valid  output  1  out_data/out_perr hold a word not yet accepted.
REQ-010 out_ready  input  1  consumer accepts the word on a cycle with out_valid=1.
REQ-011 frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-012 overrun  output  1  one-cycle pulse: a completed frame was dropped because the output register was occupied.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The frame format SHALL be: start bit (0), then N data bits LSB first, then a parity bit (only if PARITY_EN=1), then a stop bit (1).
REQ-015 The FSM SHALL have four states: IDLE, DATA, PARITY and STOP; all transitions occur only on sd_en=1 cycles.
REQ-016 IDLE:
- sd_en=1 and sd=0 -> DATA; bit counter cleared to 0.
- sd=1 -> stay in IDLE (line idle).
REQ-017 DATA: each strobe SHALL shift the data register right, shreg <= {sd, shreg[N-1:1]}, and increment the bit counter.
REQ-018 DATA exit: on the N-th data strobe -> PARITY if PARITY_EN=1, else -> STOP.
REQ-019 PARITY: on the strobe, perr_pend <= (XOR of shreg) XOR sd; then -> STOP. perr_pend = 1 means an odd total count of ones.
REQ-020 STOP with sd=1, frame good: if out_valid=0, or out_valid=1 and out_ready=1 on the same cycle:
- out_data <= shreg, out_perr <= perr_pend, out_valid <= 1 on the next cycle.
- Otherwise overrun SHALL pulse, the frame is dropped and the held word is unchanged.
- In all cases -> IDLE.
REQ-021 STOP with sd=0: frame_err SHALL pulse, the frame is discarded, the output register is untouched, and the FSM -> IDLE.
REQ-022 out_valid SHALL fall the cycle after out_valid=1 and out_ready=1, unless a new word is loaded on that same cycle.
REQ-023 out_data and out_perr SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 Latency: out_valid rises exactly one clock after the stop-bit strobe cycle.
REQ-025 frame_err and overrun SHALL be registered pulses, high for one clk only, appearing the cycle after the stop strobe.
REQ-026 When sd_en=0, state, counter and shift register SHALL hold their values.
REQ-027 The bit counter SHALL be clog2(N+1) bits wide and SHALL never exceed N-1 in DATA.

Reset
REQ-028 With reset_n=0, regardless of clk, the block SHALL go to:
- FSM in IDLE; counter, shreg and perr_pend = 0.
- out_data = 0, out_perr = 0, out_valid = 0.
- frame_err = 0, overrun = 0, busy = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame, with no pulses and no delivery. The first start bit after release SHALL begin a new frame.

Verification
REQ-030 N=4, PARITY_EN=1, out_ready=1; strobed bits 0,0,1,0,1,0,1 -> out_data=4'hA, out_perr=0, out_valid high for 1 cycle, one cycle after the stop strobe.
REQ-031 Same frame with parity bit 1 -> out_data=4'hA, out_perr=1.
REQ-032 Stop bit 0 (bits 0,1,1,1,1,0,0) -> frame_err pulses 1 cycle, out_valid stays 0, busy=0 afterwards.
REQ-033 out_ready=0; send 4'h3 then 4'h5 -> out_data remains 4'h3, overrun pulses once. Then raise out_ready -> 4'h3 is accepted and out_valid falls.
REQ-034 Accept-and-load same cycle: out_valid=1 holding 4'h3, out_ready=1 on the stop strobe of frame 4'hC -> no overrun; out_data=4'hC, out_valid stays 1.
REQ-035 Gaps and reset:
- Random sd_en gaps during a frame -> same result as a gap-free frame.
- reset_n pulsed after 2 data bits -> all outputs 0, and the next full frame 4'h6 is received correctly.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, N data bits LSB first, optional even parity, stop bit.
// Delivers each good frame through a single valid/ready output register.
module serial_frame_rx #(
   parameter int N         = 4,
   parameter int PARITY_EN = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         sd,
   input  logic         sd_en,
   output logic [N-1:0] out_data,
   output logic         out_perr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         frame_err,
   output logic         overrun,
   output logic         busy
);

   localparam int CW = $clog2(N + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   function automatic logic word_parity(input logic [N-1:0] v);
      return ^v;
   endfunction

   logic [1:0]    state_r,     state_nxt_s;
   logic [CW-1:0] cnt_r,       cnt_nxt_s;
   logic [N-1:0]  shreg_r,     shreg_nxt_s;
   logic          perr_pend_r, perr_nxt_s;
   logic          load_s, ovr_s, ferr_s;

   logic [N-1:0]  out_data_r;
   logic          out_perr_r, out_valid_r, frame_err_r, overrun_r, busy_r;

   // Next-state, shift and delivery decisions; everything advances only on a strobe.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      shreg_nxt_s = shreg_r;
      perr_nxt_s  = perr_pend_r;
      load_s      = 1'b0;
      ovr_s       = 1'b0;
      ferr_s      = 1'b0;
      if (sd_en) begin
         case (state_r)
            IDLE: begin
               if (!sd) begin
                  state_nxt_s = DATA;
                  cnt_nxt_s   = CNT_ZERO;
                  perr_nxt_s  = 1'b0;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            DATA: begin
               shreg_nxt_s = {sd, shreg_r[N-1:1]};
               if (cnt_r == CNT_LAST) begin
                  cnt_nxt_s   = CNT_ZERO;
                  state_nxt_s = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  cnt_nxt_s   = cnt_r + CNT_ONE;
               end
            end
            PARITY: begin
               perr_nxt_s  = word_parity(shreg_r) ^ sd;
               state_nxt_s = STOP;
            end
            STOP: begin
               // A word being accepted this cycle frees the register for the new one.
               if (sd) begin
                  if (!out_valid_r || out_ready) begin
                     load_s = 1'b1;
                  end else begin
                     ovr_s  = 1'b1;
                  end
               end else begin
                  ferr_s = 1'b1;
               end
               state_nxt_s = IDLE;
            end
            default: begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State, output register and status pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         cnt_r       <= CNT_ZERO;
         shreg_r     <= {N{1'b0}};
         perr_pend_r <= 1'b0;
         out_data_r  <= {N{1'b0}};
         out_perr_r  <= 1'b0;
         out_valid_r <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         shreg_r     <= shreg_nxt_s;
         perr_pend_r <= perr_nxt_s;
         frame_err_r <= ferr_s;
         overrun_r   <= ovr_s;
         busy_r      <= (state_nxt_s != IDLE);
         if (load_s) begin
            out_data_r  <= shreg_r;
            out_perr_r  <= (PARITY_EN != 0) ? perr_pend_r : 1'b0;
            out_valid_r <= 1'b1;
         end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign out_data  = out_data_r;
   assign out_perr  = out_perr_r;
   assign out_valid = out_valid_r;
   assign frame_err = frame_err_r;
   assign overrun   = overrun_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (N=4, even parity): hand-computed frames,
// latency, framing error, overrun, accept-and-load, strobe gaps and mid-frame reset.
module tb_serial_frame_rx;

   logic       clk;
   logic       reset_n;
   logic       sd;
   logic       sd_en;
   logic [3:0] out_data;
   logic       out_perr;
   logic       out_valid;
   logic       out_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_cmp;
   int n_bad;

   serial_frame_rx #(.N(4), .PARITY_EN(1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sd        (sd),
      .sd_en     (sd_en),
      .out_data  (out_data),
      .out_perr  (out_perr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One strobed bit, optionally preceded by idle cycles with a noisy line.
   task automatic strobe(input logic b, input int gap);
      logic [31:0] r;
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         r     = $urandom;
         sd    = r[0];
         sd_en = 1'b0;
      end
      @(negedge clk);
      sd    = b;
      sd_en = 1'b1;
      @(posedge clk);
      #1;
      sd_en = 1'b0;
      sd    = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start bit, data LSB first, parity bit; the stop bit is left to the caller.
   task automatic send_body(input logic [3:0] d, input logic par, input int maxgap);
      strobe(1'b0, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
      for (int i = 0; i < 4; i++) begin
         strobe(d[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
      end
      strobe(par, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      sd        = 1'b1;
      sd_en     = 1'b0;
      out_ready = 1'b1;
      reset_n   = 1'b0;
      #1;
      check("rst_data",  {28'd0, out_data}, 32'h0);
      check("rst_valid", {31'd0, out_valid}, 32'h0);
      check("rst_perr",  {31'd0, out_perr}, 32'h0);
      check("rst_busy",  {31'd0, busy}, 32'h0);
      check("rst_ferr",  {31'd0, frame_err}, 32'h0);
      check("rst_ovr",   {31'd0, overrun}, 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Frame 0,0,1,0,1,0,1 -> 4'hA, even parity ok
      strobe(1'b0, 0);
      check("busy_start", {31'd0, busy}, 32'h1);
      for (int i = 0; i < 4; i++) strobe(i[0], 0);
      strobe(1'b0, 0);
      check("a_prestop_valid", {31'd0, out_valid}, 32'h0);
      strobe(1'b1, 0);
      check("a_data",  {28'd0, out_data}, 32'hA);
      check("a_perr",  {31'd0, out_perr}, 32'h0);
      check("a_valid", {31'd0, out_valid}, 32'h1);
      check("a_busy",  {31'd0, busy}, 32'h0);
      tick();
      check("a_valid_drop", {31'd0, out_valid}, 32'h0);

      // Same data, parity bit 1 -> parity error
      send_body(4'hA, 1'b1, 0);
      strobe(1'b1, 0);
      check("ap_data", {28'd0, out_data}, 32'hA);
      check("ap_perr", {31'd0, out_perr}, 32'h1);
      tick();

      // Stop bit 0 -> framing error, nothing delivered
      send_body(4'hF, 1'b0, 0);
      strobe(1'b0, 0);
      check("fe_pulse", {31'd0, frame_err}, 32'h1);
      check("fe_valid", {31'd0, out_valid}, 32'h0);
      check("fe_busy",  {31'd0, busy}, 32'h0);
      tick();
      check("fe_pulse_end", {31'd0, frame_err}, 32'h0);

      // Overrun: 4'h3 held, 4'h5 dropped
      out_ready = 1'b0;
      send_body(4'h3, 1'b0, 0);
      strobe(1'b1, 0);
      check("ov_first_valid", {31'd0, out_valid}, 32'h1);
      send_body(4'h5, 1'b0, 0);
      strobe(1'b1, 0);
      check("ov_pulse", {31'd0, overrun}, 32'h1);
      check("ov_data",  {28'd0, out_data}, 32'h3);
      tick();
      check("ov_pulse_end", {31'd0, overrun}, 32'h0);
      check("ov_hold_data", {28'd0, out_data}, 32'h3);
      check("ov_hold_valid", {31'd0, out_valid}, 32'h1);
      out_ready = 1'b1;
      tick();
      check("ov_accept", {31'd0, out_valid}, 32'h0);

      // Accept and load on the same cycle
      out_ready = 1'b0;
      send_body(4'h3, 1'b0, 0);
      strobe(1'b1, 0);
      send_body(4'hC, 1'b0, 0);
      out_ready = 1'b1;
      strobe(1'b1, 0);
      check("al_ovr",   {31'd0, overrun}, 32'h0);
      check("al_data",  {28'd0, out_data}, 32'hC);
      check("al_valid", {31'd0, out_valid}, 32'h1);
      tick();
      check("al_drop", {31'd0, out_valid}, 32'h0);

      // Random strobe gaps give the same word
      for (int k = 0; k < 3; k++) begin
         send_body(4'h9, 1'b0, 3);
         strobe(1'b1, 2);
         check("gap_data",  {28'd0, out_data}, 32'h9);
         check("gap_perr",  {31'd0, out_perr}, 32'h0);
         check("gap_valid", {31'd0, out_valid}, 32'h1);
         tick();
      end

      // Reset after two data bits aborts the frame
      strobe(1'b0, 0);
      strobe(1'b1, 0);
      strobe(1'b1, 0);
      check("mr_busy_pre", {31'd0, busy}, 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mr_data",  {28'd0, out_data}, 32'h0);
      check("mr_busy",  {31'd0, busy}, 32'h0);
      check("mr_valid", {31'd0, out_valid}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("mr_ferr", {31'd0, frame_err}, 32'h0);
      check("mr_ovr",  {31'd0, overrun}, 32'h0);
      send_body(4'h6, 1'b0, 0);
      strobe(1'b1, 0);
      check("mr_next_data",  {28'd0, out_data}, 32'h6);
      check("mr_next_valid", {31'd0, out_valid}, 32'h1);
      check("mr_next_perr",  {31'd0, out_perr}, 32'h0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
